pc_gen: RTL and testbench

- Parametrised next-PC generator for the pipelined core; successor to the single-cycle next-PC logic.
- Owns the architectural PC register and a valid/ready fetch handshake.
- Applies execute-stage redirects (branch/jal/jalr) with priority over sequential advance, and traps misaligned targets.
- Maintains a circular return-address stack (RAS) that feeds the fetch-stage return prediction.

---
 rtl/pc_gen_pkg.sv | 9 +
 rtl/pc_gen_ras_stack.sv | 42 ++++
 rtl/pc_gen.sv | 79 +++++++
 tb/tb_pc_gen.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: next-PC operation codes shared by the PC generator and its bench.
package pc_gen_pkg;
  typedef enum logic [1:0] {
    PLUS_4 = 2'd0,
    BRANCH = 2'd1,
    JUMP   = 2'd2,
    JUMP_R = 2'd3
  } npc_op_e;
endpackage

// File: rtl/pc_gen_ras_stack.sv
// pc_gen_ras_stack: circular return-address stack; a push into a full stack overwrites the oldest entry.
module pc_gen_ras_stack #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            valid
);
  localparam int PW = $clog2(DEPTH);
  logic [XLEN-1:0] r_mem [DEPTH];
  logic [PW-1:0]   r_top;
  logic [PW:0]     r_cnt;
  logic            w_empty, w_push, w_repl, w_pop;
  assign w_empty = r_cnt == '0;
  // a combined push+pop on an empty stack degenerates to a plain push
  assign w_push  = push & (!pop | w_empty);
  assign w_repl  = push & pop & !w_empty;
  assign w_pop   = pop & !push & !w_empty;
  assign top     = r_mem[r_top];
  assign valid   = !w_empty;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_top <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_top + 1'b1] <= push_data;
      r_top <= r_top + 1'b1;
      if (r_cnt != (PW+1)'(DEPTH)) r_cnt <= r_cnt + 1'b1;
    end else if (w_repl) begin
      r_mem[r_top] <= push_data;
    end else if (w_pop) begin
      r_top <= r_top - 1'b1;
      r_cnt <= r_cnt - 1'b1;
    end
  end
endmodule

// File: rtl/pc_gen.sv
// pc_gen: architectural PC register with fetch handshake, execute-stage redirects,
// misaligned-target trapping and a return-address stack for fetch prediction.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_PC   = 32'h0000_0100,
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_ready,
  input  logic            redir_valid,
  input  logic [1:0]      npc_op,
  input  logic [XLEN-1:0] redir_pc,
  input  logic [XLEN-1:0] sext,
  input  logic            branch,
  input  logic [XLEN-1:0] alu_c,
  input  logic            is_call,
  input  logic            is_ret,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc4,
  output logic            fetch_valid,
  output logic            flush,
  output logic            misalign,
  output logic [XLEN-1:0] bad_addr,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_valid
);
  npc_op_e         w_op;
  logic [XLEN-1:0] w_target, w_link;
  logic            w_taken, w_mis, w_jump, w_push, w_pop;
  logic [XLEN-1:0] r_pc, r_bad;
  logic            r_fv, r_flush, r_mis;
  assign w_op     = npc_op_e'(npc_op);
  assign w_link   = redir_pc + XLEN'(4);
  assign w_target = w_op == JUMP_R ? alu_c & ~XLEN'(1) :
                    (w_op == BRANCH && !branch) ? w_link : redir_pc + sext;
  assign w_taken  = redir_valid && w_op != PLUS_4;
  assign w_mis    = w_taken && w_target[1:0] != 2'b00;
  assign w_jump   = redir_valid && (w_op == JUMP || w_op == JUMP_R) && !w_mis;
  assign w_push   = w_jump && is_call;
  assign w_pop    = w_jump && is_ret && w_op == JUMP_R;
  assign pc          = r_pc;
  assign pc4         = r_pc + XLEN'(4);
  assign fetch_valid = r_fv;
  assign flush       = r_flush;
  assign misalign    = r_mis;
  assign bad_addr    = r_bad;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc    <= RESET_PC;
      r_bad   <= '0;
      r_fv    <= 1'b0;
      r_flush <= 1'b0;
      r_mis   <= 1'b0;
    end else begin
      r_fv    <= 1'b1;
      r_flush <= w_taken;
      r_mis   <= w_mis;
      // redirects win over the handshake, so a stalled fetch cannot block them
      if (w_mis) begin
        r_pc  <= TRAP_PC;
        r_bad <= w_target;
      end else if (w_taken) r_pc <= w_target;
      else if (r_fv && fetch_ready) r_pc <= r_pc + XLEN'(4);
    end
  end
  pc_gen_ras_stack #(.DEPTH(RAS_DEPTH), .XLEN(XLEN)) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (w_link),
    .top       (ras_top),
    .valid     (ras_valid)
  );
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed table, hand sequences and random stimulus against a queue-based reference model.
module tb_pc_gen;
  localparam logic [31:0] TRAP = 32'h100;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 0, fetch_ready = 1, redir_valid = 0, branch = 0, is_call = 0, is_ret = 0;
  logic [1:0] npc_op = 0;
  logic [31:0] redir_pc = 0, sext = 0, alu_c = 0;
  logic [31:0] pc, pc4, bad_addr, ras_top;
  logic fetch_valid, flush, misalign, ras_valid;
  int n_chk = 0, n_pass = 0;
  logic [31:0] m_pc = 0, m_bad = 0;
  logic m_fv = 0, m_flush = 0, m_mis = 0;
  logic [31:0] m_ras[$];

  pc_gen dut (
    .clk(clk), .rst(rst), .fetch_ready(fetch_ready), .redir_valid(redir_valid), .npc_op(npc_op),
    .redir_pc(redir_pc), .sext(sext), .branch(branch), .alu_c(alu_c), .is_call(is_call),
    .is_ret(is_ret), .pc(pc), .pc4(pc4), .fetch_valid(fetch_valid), .flush(flush),
    .misalign(misalign), .bad_addr(bad_addr), .ras_top(ras_top), .ras_valid(ras_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_pc = 0; m_bad = 0; m_fv = 0; m_flush = 0; m_mis = 0; m_ras.delete();
  endtask

  task automatic model_edge();
    logic [31:0] tgt, link;
    logic taken, mis;
    link  = redir_pc + 4;
    tgt   = npc_op == 2'd3 ? {alu_c[31:1], 1'b0} :
            (npc_op == 2'd1 && !branch) ? link : redir_pc + sext;
    taken = redir_valid && npc_op != 2'd0;
    mis   = taken && tgt[1:0] != 0;
    if (redir_valid && npc_op[1] && !mis) begin
      if (is_call && is_ret && npc_op == 2'd3 && m_ras.size() != 0) m_ras[m_ras.size()-1] = link;
      else if (is_call) begin
        m_ras.push_back(link);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end else if (is_ret && npc_op == 2'd3 && m_ras.size() != 0) void'(m_ras.pop_back());
    end
    if (mis) begin m_pc = TRAP; m_bad = tgt; end
    else if (taken) m_pc = tgt;
    else if (m_fv && fetch_ready) m_pc = m_pc + 4;
    m_flush = taken; m_mis = mis; m_fv = 1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".pc"}, pc, m_pc);
    check({tag, ".pc4"}, pc4, m_pc + 4);
    check({tag, ".fetch_valid"}, 32'(fetch_valid), 32'(m_fv));
    check({tag, ".flush"}, 32'(flush), 32'(m_flush));
    check({tag, ".misalign"}, 32'(misalign), 32'(m_mis));
    check({tag, ".bad_addr"}, bad_addr, m_bad);
    check({tag, ".ras_valid"}, 32'(ras_valid), 32'(m_ras.size() != 0));
    if (m_ras.size() != 0) check({tag, ".ras_top"}, ras_top, m_ras[m_ras.size()-1]);
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk); #1;
    check_model(tag);
  endtask

  task automatic set_in(input logic fr, input logic rv, input logic [1:0] op, input logic [31:0] rp,
                        input logic [31:0] sx, input logic br, input logic [31:0] al,
                        input logic call, input logic ret);
    fetch_ready = fr; redir_valid = rv; npc_op = op; redir_pc = rp; sext = sx;
    branch = br; alu_c = al; is_call = call; is_ret = ret;
  endtask

  typedef struct {
    logic fr, rv; logic [1:0] op; logic [31:0] rp, sx; logic br; logic [31:0] al;
    logic [31:0] e_pc; logic e_flush, e_mis; logic [31:0] e_bad;
  } vec_t;
  vec_t vt[8];

  initial begin
    vt[0] = '{0, 1, 2'd1, 32'h40, 32'hFFFF_FFF0, 1, 0, 32'h30, 1, 0, 32'h0};
    vt[1] = '{0, 0, 2'd0, 0, 0, 0, 0, 32'h30, 0, 0, 32'h0};
    vt[2] = '{0, 1, 2'd1, 32'h40, 32'hFFFF_FFF0, 0, 0, 32'h44, 1, 0, 32'h0};
    vt[3] = '{0, 1, 2'd3, 0, 0, 0, 32'h103, 32'h100, 1, 1, 32'h102};
    vt[4] = '{1, 0, 2'd0, 0, 0, 0, 0, 32'h104, 0, 0, 32'h102};
    vt[5] = '{0, 1, 2'd3, 0, 0, 0, 32'h205, 32'h204, 1, 0, 32'h102};
    vt[6] = '{1, 1, 2'd0, 32'h500, 32'h6, 1, 32'h7, 32'h208, 0, 0, 32'h102};
    vt[7] = '{1, 1, 2'd2, 32'h1000, 32'h6, 0, 0, 32'h100, 1, 1, 32'h1006};

    #12;
    check_model("reset");
    rst = 1; #1;
    check("release.fetch_valid", 32'(fetch_valid), 0);
    step("boot0"); check("boot0.pc", pc, 32'h0);
    step("boot1"); check("boot1.pc", pc, 32'h4);
    step("boot2"); check("boot2.pc", pc, 32'h8);
    step("adv"); step("adv");
    fetch_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step("stall"); check("stall.pc", pc, 32'h10); check("stall.pc4", pc4, 32'h14);
    end

    foreach (vt[i]) begin
      set_in(vt[i].fr, vt[i].rv, vt[i].op, vt[i].rp, vt[i].sx, vt[i].br, vt[i].al, 0, 0);
      step($sformatf("vec%0d", i));
      check($sformatf("vec%0d.pc_tbl", i), pc, vt[i].e_pc);
      check($sformatf("vec%0d.flush_tbl", i), 32'(flush), 32'(vt[i].e_flush));
      check($sformatf("vec%0d.mis_tbl", i), 32'(misalign), 32'(vt[i].e_mis));
      check($sformatf("vec%0d.bad_tbl", i), bad_addr, vt[i].e_bad);
    end

    for (int i = 0; i < 5; i++) begin
      set_in(1, 1, 2'd2, 32'(i * 16), 32'h100, 0, 0, 1, 0);
      step("call");
    end
    check("ras5.top", ras_top, 32'h44);
    for (int i = 0; i < 5; i++) begin
      set_in(1, 1, 2'd3, 0, 0, 0, 32'h200, 0, 1);
      step("ret");
      if (i < 3) check($sformatf("ret%0d.top", i), ras_top, 32'h34 - 32'(i * 16));
      check($sformatf("ret%0d.valid", i), 32'(ras_valid), 32'(i < 3));
    end

    set_in(1, 1, 2'd2, 32'h60, 32'h40, 0, 0, 1, 0); step("co.call0");
    set_in(1, 1, 2'd2, 32'h70, 32'h40, 0, 0, 1, 0); step("co.call1");
    set_in(1, 1, 2'd3, 32'h80, 0, 0, 32'h300, 1, 1); step("co.swap");
    check("co.top", ras_top, 32'h84);
    set_in(1, 1, 2'd3, 0, 0, 0, 32'h300, 0, 1); step("co.pop1");
    check("co.pop1.top", ras_top, 32'h64);
    check("co.pop1.valid", 32'(ras_valid), 1);
    step("co.pop2");
    check("co.pop2.valid", 32'(ras_valid), 0);

    set_in(1, 1, 2'd3, 0, 0, 0, 32'h103, 1, 0); step("pre_rst");
    check("pre_rst.flush", 32'(flush), 1);
    #2 rst = 0; #1;
    model_reset();
    check_model("async_rst");
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1;

    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)),
             32'($urandom_range(0, 1023)) << 2,
             $urandom_range(0, 7) == 0 ? $urandom : 32'($urandom_range(0, 255)) << 2,
             1'($urandom), $urandom_range(0, 7) == 0 ? $urandom : 32'($urandom_range(0, 511)) << 2,
             1'($urandom), 1'($urandom));
      step("rand");
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
